// File: rtl/sa_mem_sequencer.sv
// Memory transaction sequencer: pops one queue entry at a time, runs a fixed-latency
// single-port read or write access, then issues a one-cycle completion.
module sa_mem_sequencer #(
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        q_valid,
  input  logic [56:0] q_entry,
  output logic        q_pop,
  output logic        cs,
  output logic        we,
  output logic [15:0] addr,
  output logic [31:0] mem_dout,
  output logic        mem_dout_en,
  input  logic [31:0] mem_din,
  output logic        done,
  output logic [3:0]  done_owner,
  output logic [3:0]  done_id,
  output logic        done_we,
  output logic [31:0] done_rdata,
  output logic        busy
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CW      = (MAX_LAT <= 7) ? 3 : $clog2(MAX_LAT + 1);

  generate
    if (READ_LAT < 1 || WRITE_LAT < 1) begin : g_lat_check
      $error("sa_mem_sequencer: READ_LAT and WRITE_LAT must both be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [56:0]   work_q, work_d;
  logic [56:0]   ent;
  logic          cs_q, cs_d, we_q, we_d, dout_en_q, dout_en_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   dout_q, dout_d;
  logic          done_q, done_d, done_we_q, done_we_d;
  logic [3:0]    done_owner_q, done_owner_d, done_id_q, done_id_d;
  logic [31:0]   rdata_q, rdata_d;

  assign q_pop = rst_n && q_valid && (state_q == IDLE || state_q == DONE);
  assign busy  = (state_q == ACCESS) || (state_q == DONE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    work_d       = work_q;
    done_d       = 1'b0;
    done_owner_d = done_owner_q;
    done_id_d    = done_id_q;
    done_we_d    = done_we_q;
    rdata_d      = rdata_q;
    ent          = q_pop ? q_entry : work_q;

    case (state_q)
      IDLE, DONE: begin
        if (q_pop) begin
          state_d = ACCESS;
          work_d  = q_entry;
          cnt_d   = q_entry[8] ? CW'(WRITE_LAT) : CW'(READ_LAT);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d      = DONE;
          done_d       = 1'b1;
          done_owner_d = work_q[3:0];
          done_id_d    = work_q[7:4];
          done_we_d    = work_q[8];
          rdata_d      = work_q[8] ? 32'h0 : mem_din;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus pins are registered from the next state so they line up with ACCESS cycles.
    cs_d      = 1'b0;
    we_d      = 1'b0;
    dout_en_d = 1'b0;
    dout_d    = 32'h0;
    addr_d    = addr_q;
    if (state_d == ACCESS) begin
      cs_d      = 1'b1;
      we_d      = ent[8];
      dout_en_d = ent[8];
      dout_d    = ent[8] ? ent[40:9] : 32'h0;
      addr_d    = ent[56:41];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      work_q       <= '0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      dout_en_q    <= 1'b0;
      addr_q       <= '0;
      dout_q       <= '0;
      done_q       <= 1'b0;
      done_owner_q <= '0;
      done_id_q    <= '0;
      done_we_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      work_q       <= work_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      dout_en_q    <= dout_en_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      done_q       <= done_d;
      done_owner_q <= done_owner_d;
      done_id_q    <= done_id_d;
      done_we_q    <= done_we_d;
      rdata_q      <= rdata_d;
    end
  end

  assign cs          = cs_q;
  assign we          = we_q;
  assign mem_dout_en = dout_en_q;
  assign addr        = addr_q;
  assign mem_dout    = dout_q;
  assign done        = done_q;
  assign done_owner  = done_owner_q;
  assign done_id     = done_id_q;
  assign done_we     = done_we_q;
  assign done_rdata  = rdata_q;

endmodule

// File: tb/tb_sa_mem_sequencer.sv
// Directed bench for sa_mem_sequencer with READ_LAT=2, WRITE_LAT=1.
module tb_sa_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        q_valid;
  logic [56:0] q_entry;
  logic        q_pop, cs, we, mem_dout_en, done, done_we, busy;
  logic [15:0] addr;
  logic [31:0] mem_dout, mem_din, done_rdata;
  logic [3:0]  done_owner, done_id;

  int total = 0;
  int bad   = 0;

  sa_mem_sequencer #(.READ_LAT(2), .WRITE_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .q_valid(q_valid), .q_entry(q_entry), .q_pop(q_pop),
    .cs(cs), .we(we), .addr(addr), .mem_dout(mem_dout), .mem_dout_en(mem_dout_en),
    .mem_din(mem_din), .done(done), .done_owner(done_owner), .done_id(done_id),
    .done_we(done_we), .done_rdata(done_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [56:0] mk(input logic [3:0] owner, input logic [3:0] id,
                                     input logic typ, input logic [31:0] data,
                                     input logic [15:0] a);
    return {a, data, typ, id, owner};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle: inputs are driven 1 ns after the edge, checks 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [56:0] ea, eb, ec;
    logic        exp_pop, exp_cs, exp_done;

    rst_n   = 1'b0;
    q_valid = 1'b0;
    q_entry = '0;
    mem_din = '0;
    #2;
    chk("rst_ctl", {60'h0, q_pop, cs, done, busy}, 64'h0);
    chk("rst_bus", {we, mem_dout_en, addr, mem_dout}, 64'h0);
    chk("rst_done", {done_we, done_owner, done_id, done_rdata}, 64'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single read: pop at T, cs at T+1..T+2, done at T+3.
    q_valid = 1'b1;
    q_entry = mk(4'd2, 4'd5, 1'b0, 32'h1111_2222, 16'h0040);
    #1;
    chk("rd_pop_T", q_pop, 1);
    chk("rd_cs_T", cs, 0);
    step();
    q_valid = 1'b0;
    q_entry = '0;
    #1;
    chk("rd_T1_bus", {cs, we, mem_dout_en, addr}, {1'b1, 1'b0, 1'b0, 16'h0040});
    chk("rd_T1_busy", {q_pop, busy, done}, 3'b010);
    step();
    mem_din = 32'hDEADBEEF;
    #1;
    chk("rd_T2_cs", {cs, we, done}, 3'b100);
    step();
    mem_din = 32'h0;
    #1;
    chk("rd_T3_done", {cs, done, done_we}, 3'b010);
    chk("rd_T3_fields", {done_owner, done_id, done_rdata}, {4'd2, 4'd5, 32'hDEADBEEF});
    step();
    #1;
    chk("rd_T4_idle", {done, busy, cs}, 3'b000);

    // Single write: bus at T+1, done at T+2 with zero read data.
    q_valid = 1'b1;
    q_entry = mk(4'd3, 4'd6, 1'b1, 32'hA5A5_5A5A, 16'h1234);
    #1;
    chk("wr_pop_T", q_pop, 1);
    step();
    q_valid = 1'b0;
    #1;
    chk("wr_T1_ctl", {cs, we, mem_dout_en, done}, 4'b1110);
    chk("wr_T1_bus", {addr, mem_dout}, {16'h1234, 32'hA5A5_5A5A});
    step();
    #1;
    chk("wr_T2_done", {done, done_we, cs, we, mem_dout_en}, 5'b11000);
    chk("wr_T2_fields", {done_owner, done_id, done_rdata}, {4'd3, 4'd6, 32'h0});
    chk("wr_T2_dout", mem_dout, 32'h0);
    step();

    // Back-to-back read, write, read with q_valid held high.
    ea = mk(4'd1, 4'd1, 1'b0, 32'h0, 16'h0100);
    eb = mk(4'd2, 4'd2, 1'b1, 32'hCAFE_F00D, 16'h0200);
    ec = mk(4'd3, 4'd3, 1'b0, 32'h0, 16'h0300);
    for (int c = 0; c < 10; c++) begin
      q_valid = (c <= 5);
      q_entry = (c == 0) ? ea : (c <= 3) ? eb : (c <= 5) ? ec : 57'h0;
      mem_din = 32'h1000 + c;
      #1;
      exp_pop  = (c == 0) || (c == 3) || (c == 5);
      exp_done = (c == 3) || (c == 5) || (c == 8);
      exp_cs   = (c == 1) || (c == 2) || (c == 4) || (c == 6) || (c == 7);
      chk($sformatf("b2b_c%0d_pop", c), q_pop, exp_pop);
      chk($sformatf("b2b_c%0d_cs", c), cs, exp_cs);
      chk($sformatf("b2b_c%0d_done", c), done, exp_done);
      if (c == 3) chk("b2b_done_a", {done_id, done_rdata}, {4'd1, 32'h1002});
      if (c == 4) chk("b2b_wr_bus", {we, addr, mem_dout}, {1'b1, 16'h0200, 32'hCAFE_F00D});
      if (c == 5) chk("b2b_done_b", {done_id, done_we, done_rdata}, {4'd2, 1'b1, 32'h0});
      if (c == 8) chk("b2b_done_c", {done_id, done_rdata}, {4'd3, 32'h1007});
      step();
    end

    // Reset dropped during the first access cycle of a read.
    q_valid = 1'b1;
    q_entry = mk(4'd4, 4'd7, 1'b0, 32'h0, 16'h0777);
    #1;
    chk("rst_mid_pop", q_pop, 1);
    step();
    q_entry = mk(4'd4, 4'd9, 1'b0, 32'h0, 16'h0999);
    #1;
    chk("rst_mid_cs_pre", cs, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async", {cs, done, busy, q_pop}, 4'b0000);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_rel_pop", q_pop, 1);
    step();
    #1;
    chk("rst_rel_cs", {cs, addr}, {1'b1, 16'h0999});
    q_valid = 1'b0;
    step();
    #1;
    chk("rst_rel_nodone", done, 0);
    step();
    #1;
    chk("rst_rel_done", {done, done_id}, {1'b1, 4'd9});
    step();

    // Idle stability with a noisy head entry.
    q_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      q_entry = {$urandom(), $urandom()};
      #1;
      chk($sformatf("idle_c%0d", c), {q_pop, cs, done, busy}, 4'b0000);
      step();
    end

    // All-ones owner/ID/address pass through untouched.
    q_valid = 1'b1;
    q_entry = mk(4'hF, 4'hF, 1'b0, 32'h0, 16'hFFFF);
    mem_din = 32'h0BAD_F00D;
    step();
    q_valid = 1'b0;
    #1;
    chk("pt_addr", {cs, addr}, {1'b1, 16'hFFFF});
    step();
    step();
    #1;
    chk("pt_done", {done, done_owner, done_id, done_rdata}, {1'b1, 4'hF, 4'hF, 32'h0BAD_F00D});
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sa_mem_sequencer.md
# sa_mem_sequencer

Memory transaction sequencer for the system agent. It pops one entry at a time from the head of the agent's transaction queue and drives the single-port memory interface through a fixed-latency read or write access. It then returns a one-cycle completion (owner, transaction ID, read data) to the IP response path. It sits between `sa_tx_queue_regs` and the external memory pins, and is the only block that drives cs/we/addr.

## Interface
- `READ_LAT`, 2: cycles cs is held for a read; mem_din is sampled at the end of the last one; must be ≥1.
- `WRITE_LAT`, 1: cycles cs/we are held for a write; must be ≥1.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `q_valid`  in  1  queue head holds a valid transaction.
- `q_entry`  in  57  head entry: [3:0] owner, [7:4] tx ID, [8] type (1=write, 0=read), [40:9] write data, [56:41] address.
- `q_pop`  out  1  head consumed this cycle; combinational.
- `cs`  out  1  memory chip select.
- `we`  out  1  memory write enable.
- `addr`  out  16  memory address.
- `mem_dout`  out  32  write data toward memory.
- `mem_dout_en`  out  1  tristate enable for mem_dout; the top level builds the inout `data` bus from it.
- `mem_din`  in  32  read data from memory.
- `done`  out  1  one-cycle completion pulse.
- `done_owner`  out  4  owner field of the completed transaction.
- `done_id`  out  4  tx ID of the completed transaction.
- `done_we`  out  1  type of the completed transaction.
- `done_rdata`  out  32  read data; 0 for writes.
- `busy`  out  1  high in ACCESS or DONE.

## Operation
- The FSM has three states: IDLE, ACCESS, DONE.
- **q_pop:** asserted when (state==IDLE or state==DONE) and q_valid; it is 0 in every other case.
- **IDLE:**
  - If q_pop, latch q_entry into the working register.
  - Load the counter with READ_LAT or WRITE_LAT according to q_entry[8].
  - Go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS:**
  - cs=1, we=type, addr=latched address.
  - For a write, mem_dout=latched data and mem_dout_en=1. For a read, mem_dout_en=0.
  - The counter decrements each cycle.
  - When the counter is 1: for a read, capture mem_din into done_rdata; for a write, clear done_rdata to 0. Then go to DONE.
- **DONE:**
  - done=1; done_owner, done_id and done_we reflect the latched entry.
  - cs, we and mem_dout_en are 0.
  - If q_pop, latch the new entry and go to ACCESS; otherwise go to IDLE.
- cs, we, addr, mem_dout, mem_dout_en and all done_* outputs are registered, not decoded combinationally.
- The counter is 3 bits wide when max(READ_LAT, WRITE_LAT) ≤7; otherwise it is $clog2(max+1) bits. An elaboration-time check rejects a latency of 0.
- q_entry is sampled only in the cycle q_pop is high. Later changes to q_valid or q_entry do not affect the transaction in flight.
- The block does not interpret the owner or ID fields; it passes them through unchanged (4'hF is legal).

## Timing
- **Reset:** while rst_n=0, immediately (asynchronously):
  - state=IDLE, counter=0, working register=0;
  - cs=we=mem_dout_en=done=done_we=0; addr=0, mem_dout=0, done_owner=0, done_id=0, done_rdata=0; busy=0.
  - q_pop is 0 because the state is IDLE and it is gated by rst_n.
- **Latency:** an entry popped in cycle T gives:
  - cs high in cycles T+1 .. T+LAT;
  - done high in cycle T+LAT+1.
- **Back-to-back:** with q_valid held high, the sequence is one transaction every LAT+1 cycles. cs is low for exactly one cycle (the DONE cycle) between accesses. This gap is the bus turnaround.
- **Read capture:** mem_din is sampled at the rising edge that ends cycle T+READ_LAT.
- **Write data:** mem_dout is driven for exactly the WRITE_LAT cycles that we is high, and mem_dout_en matches we cycle-for-cycle.
- **Reset mid-operation:** the in-flight transaction is dropped and done is not issued. The queue entry was already popped and is not re-requested. The first q_pop after reset release occurs in the first cycle with rst_n=1 and q_valid=1.
- **q_valid low in DONE:** the block returns to IDLE; the next pop costs one extra cycle.

## Test plan
- **Single read, READ_LAT=2:**
  - Stimulus: entry addr=16'h0040, owner=2, ID=5, type=0; q_valid pulses one cycle at T; mem_din=32'hDEADBEEF during T+2.
  - Required: q_pop=1 at T; cs=1, we=0 at T+1..T+2; done=1 at T+3 with done_owner=2, done_id=5, done_rdata=32'hDEADBEEF.
- **Single write, WRITE_LAT=1:**
  - Stimulus: entry addr=16'h1234, data=32'hA5A5_5A5A, type=1.
  - Required: at T+1, cs=we=mem_dout_en=1, addr=16'h1234, mem_dout=32'hA5A5_5A5A; at T+2, done=1, done_we=1, done_rdata=0.
- **Back-to-back:**
  - Stimulus: q_valid held high for 3 entries (read, write, read); READ_LAT=2, WRITE_LAT=1.
  - Required: q_pop at T, T+3, T+5; done at T+3, T+5, T+8; cs low only in the DONE cycles.
- **Reset mid-access:**
  - Stimulus: rst_n dropped asynchronously during cycle T+1 of a read.
  - Required: cs=0 and done=0 immediately; no done for that ID after release; the next entry is popped on the first cycle after release.
- **Idle stability:**
  - Stimulus: q_valid=0 and q_entry toggling randomly for 20 cycles.
  - Required: q_pop, cs and done remain 0; busy=0.
- **Field passthrough:**
  - Stimulus: owner=4'hF, ID=4'hF, addr=16'hFFFF read.
  - Required: addr=16'hFFFF on the bus; done_owner=4'hF, done_id=4'hF.
